// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: shifting scoreboard of in-flight register writes,
// MDU busy counter and CP0 (EPC/Status) write guard for ERET.
module hazard_scoreboard #(
    parameter int DEPTH       = 3,
    parameter int TW          = 3,
    parameter int MUL_CYCLES  = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int GUARD_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          d_valid,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [4:0]    d_dst,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_access,
    input  logic          d_eret,
    input  logic          d_mtc0,
    input  logic [4:0]    d_cp0_addr,
    output logic          stall,
    output logic [3:0]    stall_cause,
    output logic          mdu_busy
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic          r_valid [DEPTH];
    logic [4:0]    r_dst   [DEPTH];
    logic [TW-1:0] r_tnew  [DEPTH];
    logic          r_guard [DEPTH];
    logic [CW-1:0] r_md_cnt;

    logic          w_rs_hit;
    logic          w_rt_hit;
    logic          w_guard_hit;
    logic          w_eret_hit;
    logic          w_mdu_hit;
    logic          w_accept;
    logic          w_d_guard;
    logic [TW-1:0] w_d_tnew;

    // Register hazards: a producer blocks D only while its result is later than the use.
    always_comb begin
        w_rs_hit    = 1'b0;
        w_rt_hit    = 1'b0;
        w_guard_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[k] && (r_dst[k] != 5'd0)) begin
                if ((r_dst[k] == d_rs) && (d_tuse_rs < r_tnew[k]))
                    w_rs_hit = 1'b1;
                if ((r_dst[k] == d_rt) && (d_tuse_rt < r_tnew[k]))
                    w_rt_hit = 1'b1;
            end
        end
        for (int k = 0; k < GUARD_DEPTH; k++) begin
            if (r_valid[k] && r_guard[k])
                w_guard_hit = 1'b1;
        end
    end

    assign mdu_busy    = (r_md_cnt != '0);
    assign w_mdu_hit   = d_valid && d_md_access && mdu_busy;
    assign w_eret_hit  = d_valid && d_eret && w_guard_hit;
    assign stall_cause = {w_eret_hit, w_mdu_hit, w_rt_hit, w_rs_hit};
    assign stall       = |stall_cause;

    assign w_accept  = d_valid && !stall;
    assign w_d_guard = d_mtc0 && ((d_cp0_addr == 5'd12) || (d_cp0_addr == 5'd14));
    assign w_d_tnew  = (d_tnew == '0) ? '0 : d_tnew - TW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_dst[k]   <= '0;
                r_tnew[k]  <= '0;
                r_guard[k] <= 1'b0;
            end
            r_md_cnt <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_valid[k] <= r_valid[k-1] && !flush;
                r_dst[k]   <= r_dst[k-1];
                r_tnew[k]  <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TW'(1);
                r_guard[k] <= r_guard[k-1];
            end
            // Entry 0 takes the accepted D instruction even during a flush.
            r_valid[0] <= w_accept;
            r_dst[0]   <= d_dst;
            r_tnew[0]  <= w_d_tnew;
            r_guard[0] <= w_d_guard;

            if (w_accept && d_md_start)
                r_md_cnt <= d_md_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            else if (r_md_cnt != '0)
                r_md_cnt <= r_md_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle vector table plus MDU window sequences.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset, flush, d_valid;
    logic [4:0] d_rs, d_rt, d_dst, d_cp0_addr;
    logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_md_access, d_eret, d_mtc0;
    logic       stall, mdu_busy;
    logic [3:0] stall_cause;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .d_md_access(d_md_access), .d_eret(d_eret), .d_mtc0(d_mtc0),
        .d_cp0_addr(d_cp0_addr), .stall(stall), .stall_cause(stall_cause),
        .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        bit       rst, fl, v;
        bit [4:0] rs, rt, dst, cp0;
        bit [2:0] trs, trt, tn;
        bit       mds, mdd, mda, eret, mtc0;
        bit       e_stall;
        bit [3:0] e_cause;
        bit       e_busy;
    } vec_t;

    vec_t q[$];

    function automatic vec_t mk(string n, bit v, bit [4:0] rs, bit [2:0] trs,
                                bit [4:0] rt, bit [2:0] trt, bit [4:0] dst, bit [2:0] tn,
                                bit s, bit [3:0] c, bit b);
        vec_t t;
        t.name = n; t.rst = 0; t.fl = 0; t.v = v;
        t.rs = rs; t.trs = trs; t.rt = rt; t.trt = trt; t.dst = dst; t.tn = tn;
        t.mds = 0; t.mdd = 0; t.mda = 0; t.eret = 0; t.mtc0 = 0; t.cp0 = 0;
        t.e_stall = s; t.e_cause = c; t.e_busy = b;
        return t;
    endfunction

    function automatic vec_t fx(vec_t t, bit rst, bit fl, bit mds, bit mdd, bit mda,
                                bit eret, bit mtc0, bit [4:0] cp0);
        vec_t r = t;
        r.rst = rst; r.fl = fl; r.mds = mds; r.mdd = mdd; r.mda = mda;
        r.eret = eret; r.mtc0 = mtc0; r.cp0 = cp0;
        return r;
    endfunction

    task automatic drive(input vec_t t);
        reset = t.rst; flush = t.fl; d_valid = t.v;
        d_rs = t.rs; d_tuse_rs = t.trs; d_rt = t.rt; d_tuse_rt = t.trt;
        d_dst = t.dst; d_tnew = t.tn;
        d_md_start = t.mds; d_md_div = t.mdd; d_md_access = t.mda;
        d_eret = t.eret; d_mtc0 = t.mtc0; d_cp0_addr = t.cp0;
    endtask

    task automatic check(input string n, input bit s, input bit [3:0] c, input bit b);
        n_tests++;
        if (stall !== s || stall_cause !== c || mdu_busy !== b) begin
            n_fail++;
            $display("FAIL %s: got stall=%b cause=%b busy=%b, want stall=%b cause=%b busy=%b",
                     n, stall, stall_cause, mdu_busy, s, c, b);
        end
    endtask

    task automatic md_window(input bit is_div, input int n);
        vec_t t;
        t = fx(mk("md_start", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 1, is_div, 1, 0, 0, 0);
        @(negedge clk); drive(t); #1; check(t.name, 0, 4'b0000, 0);
        t = fx(mk("md_mf", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk); drive(t); #1;
            check(is_div ? "div_wait" : "mul_wait", 1, 4'b0100, 1);
        end
        @(negedge clk); drive(t); #1;
        check(is_div ? "div_release" : "mul_release", 0, 4'b0000, 0);
    endtask

    initial begin
        // reset state with arbitrary D inputs
        q.push_back(fx(mk("rst_state", 1, 5, 0, 6, 0, 7, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 1, 1, 0, 0));
        // load-use
        q.push_back(mk("lu_lw",    1, 0, 0, 0, 0, 1, 3, 0, 4'b0000, 0));
        q.push_back(mk("lu_stall", 1, 1, 1, 0, 0, 0, 0, 1, 4'b0001, 0));
        q.push_back(mk("lu_go",    1, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 0));
        // branch after ALU
        q.push_back(mk("br_alu",   1, 0, 0, 0, 0, 2, 2, 0, 4'b0000, 0));
        q.push_back(mk("br_stall", 1, 0, 0, 2, 0, 0, 0, 1, 4'b0010, 0));
        q.push_back(mk("br_go",    1, 0, 0, 2, 0, 0, 0, 0, 4'b0000, 0));
        q.push_back(mk("br0_alu",  1, 0, 0, 0, 0, 0, 2, 0, 4'b0000, 0));
        q.push_back(mk("br0_chk",  1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
        // both sources, tnew counting down through entries
        q.push_back(mk("both_prod", 1, 0, 0, 0, 0, 9, 3, 0, 4'b0000, 0));
        q.push_back(mk("both_e0",   1, 9, 0, 9, 1, 0, 0, 1, 4'b0011, 0));
        q.push_back(mk("both_e1",   1, 9, 0, 9, 1, 0, 0, 1, 4'b0001, 0));
        q.push_back(mk("both_e2",   1, 9, 0, 9, 1, 0, 0, 0, 4'b0000, 0));
        // ERET guard
        q.push_back(fx(mk("mtc0_14", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 0, 0, 1, 14));
        q.push_back(fx(mk("eret_s1", 1, 0, 0, 0, 0, 0, 0, 1, 4'b1000, 0), 0, 0, 0, 0, 0, 1, 0, 0));
        q.push_back(fx(mk("eret_s2", 1, 0, 0, 0, 0, 0, 0, 1, 4'b1000, 0), 0, 0, 0, 0, 0, 1, 0, 0));
        q.push_back(fx(mk("eret_go", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 0, 1, 0, 0));
        q.push_back(fx(mk("mtc0_13", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 0, 0, 1, 13));
        q.push_back(fx(mk("eret_13", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 0, 1, 0, 0));
        q.push_back(fx(mk("mtc0_12", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 0, 0, 1, 12));
        q.push_back(fx(mk("eret12_1", 1, 0, 0, 0, 0, 0, 0, 1, 4'b1000, 0), 0, 0, 0, 0, 0, 1, 0, 0));
        q.push_back(fx(mk("eret12_2", 1, 0, 0, 0, 0, 0, 0, 1, 4'b1000, 0), 0, 0, 0, 0, 0, 1, 0, 0));
        q.push_back(fx(mk("eret12_go", 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 0, 1, 0, 0));
        // flush with a mult running
        q.push_back(fx(mk("fl_mul",   1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 1, 0, 1, 0, 0, 0));
        q.push_back(mk("fl_lw",       1, 0, 0, 0, 0, 3, 3, 0, 4'b0000, 1));
        q.push_back(fx(mk("fl_stall", 1, 3, 0, 0, 0, 0, 0, 1, 4'b0001, 1), 0, 1, 0, 0, 0, 0, 0, 0));
        q.push_back(mk("fl_after",    1, 3, 0, 0, 0, 0, 0, 0, 4'b0000, 1));
        q.push_back(fx(mk("fl_mf2",   1, 0, 0, 0, 0, 0, 0, 1, 4'b0100, 1), 0, 0, 0, 0, 1, 0, 0, 0));
        q.push_back(fx(mk("fl_mf1",   1, 0, 0, 0, 0, 0, 0, 1, 4'b0100, 1), 0, 0, 0, 0, 1, 0, 0, 0));
        q.push_back(fx(mk("fl_mf0",   1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 1, 0, 0, 0));
        // reset in the middle of a divide
        q.push_back(fx(mk("rd_div",   1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 1, 1, 1, 0, 0, 0));
        q.push_back(mk("rd_lw",       1, 0, 0, 0, 0, 5, 3, 0, 4'b0000, 1));
        q.push_back(mk("rd_bubble",   0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1));
        q.push_back(fx(mk("rd_rst",   1, 5, 0, 0, 0, 0, 0, 1, 4'b0101, 1), 1, 0, 0, 0, 1, 0, 0, 0));
        q.push_back(fx(mk("rd_after", 1, 5, 0, 0, 0, 0, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 1, 0, 0, 0));
        // reset and flush together: nothing loaded
        q.push_back(mk("fr_prod",     1, 0, 0, 0, 0, 6, 3, 0, 4'b0000, 0));
        q.push_back(fx(mk("fr_both",  1, 0, 0, 0, 0, 7, 3, 0, 4'b0000, 0), 1, 1, 0, 0, 0, 0, 0, 0));
        q.push_back(mk("fr_after",    1, 7, 0, 6, 0, 0, 0, 0, 4'b0000, 0));

        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (q[i]) begin
            @(negedge clk);
            drive(q[i]);
            #1;
            check(q[i].name, q[i].e_stall, q[i].e_cause, q[i].e_busy);
        end

        md_window(1'b1, 10);
        md_window(1'b0, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
